// File: rtl/reset_seq_pkg.sv
// Shared state encoding and counter sizing helper for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        StHold     = 3'd0,
        StWaitLock = 3'd1,
        StRelease  = 3'd2,
        StInit     = 3'd3,
        StReady    = 3'd4
    } state_e;

    localparam int unsigned StateW = 3;

    // True when value is representable in an unsigned counter of the given width.
    function automatic bit fits_cnt(longint unsigned value, int unsigned width);
        return value <= ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic data_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            meta_q     <= data_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~sync_dly_q;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Multi-stage reset sequencer: hold, filtered PLL lock wait, staggered stage release,
// init window, ready. Restarts on a trigger rising edge or on loss of lock.
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 3,
    parameter int unsigned RESET_CYCLES = 2**27 - 1,
    parameter int unsigned LOCK_FILTER  = 16,
    parameter int unsigned STAGE_GAP    = 4,
    parameter int unsigned INIT_CYCLES  = 2**27 - 1,
    parameter int unsigned CNT_W        = 27
) (
    input  logic                  i_slowest_clk,
    input  logic                  i_rst_n,
    input  logic                  i_reset_trigger,
    input  logic                  i_pll_locked,
    input  logic                  i_clear_sticky,
    output logic [NUM_STAGES-1:0] o_reset,
    output logic                  o_await_initialization,
    output logic                  o_ready,
    output logic [StateW-1:0]     o_state,
    output logic                  o_lock_lost_sticky
);

    localparam bit CfgOk = (NUM_STAGES >= 1) && (RESET_CYCLES >= 1) && (LOCK_FILTER >= 1) &&
                           (STAGE_GAP >= 1) && (INIT_CYCLES >= 1) &&
                           fits_cnt(longint'(RESET_CYCLES), CNT_W) &&
                           fits_cnt(longint'(LOCK_FILTER), CNT_W) &&
                           fits_cnt(longint'(STAGE_GAP), CNT_W) &&
                           fits_cnt(longint'(INIT_CYCLES), CNT_W) &&
                           fits_cnt(longint'(NUM_STAGES) * longint'(STAGE_GAP), CNT_W);

    if (!CfgOk) begin : gen_cfg_err
        $error("reset_seq_ctrl: cycle parameters out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] RelLast  = CNT_W'((NUM_STAGES - 1) * STAGE_GAP);
    localparam logic [CNT_W-1:0] InitLast = CNT_W'(INIT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] reset_q, reset_d;
    logic                  await_q, await_d;
    logic                  ready_q, ready_d;
    logic                  sticky_q, sticky_d;

    logic trig_rise;
    logic trig_level_unused;
    logic lock_sync;
    logic unused_lock_rise;
    logic lock_lost;

    sync_edge_detect u_sync_trigger (
        .clk_i   (i_slowest_clk),
        .rst_ni  (i_rst_n),
        .data_i  (i_reset_trigger),
        .level_o (trig_level_unused),
        .rise_o  (trig_rise)
    );

    sync_edge_detect u_sync_lock (
        .clk_i   (i_slowest_clk),
        .rst_ni  (i_rst_n),
        .data_i  (i_pll_locked),
        .level_o (lock_sync),
        .rise_o  (unused_lock_rise)
    );

    // Next state and shared counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lock_lost = 1'b0;

        case (state_q)
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StWaitLock: begin
                if (!lock_sync) begin
                    cnt_d = '0;
                end else if (cnt_q == LockLast) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StRelease: begin
                if (cnt_q == RelLast) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StInit: begin
                if (cnt_q == InitLast) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StReady: begin
                cnt_d = '0;
            end
            default: begin
                state_d = StHold;
                cnt_d   = '0;
            end
        endcase

        if (!lock_sync && (state_q inside {StRelease, StInit, StReady})) begin
            lock_lost = 1'b1;
        end

        // Restart events override any in-state progress.
        if (lock_lost || trig_rise) begin
            state_d = StHold;
            cnt_d   = '0;
        end
    end

    // Registered outputs are derived from the next state so they line up with o_state.
    always_comb begin
        reset_d = reset_q;
        case (state_d)
            StRelease: begin
                for (int k = 0; k < int'(NUM_STAGES); k++) begin
                    if (cnt_d == CNT_W'(k * int'(STAGE_GAP))) begin
                        reset_d[k] = 1'b0;
                    end
                end
            end
            StInit, StReady: reset_d = '0;
            default:         reset_d = '1;
        endcase

        ready_d  = (state_d == StReady);
        await_d  = ~ready_d;
        sticky_d = lock_lost ? 1'b1 : (i_clear_sticky ? 1'b0 : sticky_q);
    end

    always_ff @(posedge i_slowest_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StHold;
            cnt_q    <= '0;
            reset_q  <= '1;
            await_q  <= 1'b1;
            ready_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reset_q  <= reset_d;
            await_q  <= await_d;
            ready_q  <= ready_d;
            sticky_q <= sticky_d;
        end
    end

    logic unused_trig_level;
    assign unused_trig_level = trig_level_unused;

    assign o_reset                = reset_q;
    assign o_await_initialization = await_q;
    assign o_ready                = ready_q;
    assign o_state                = state_q;
    assign o_lock_lost_sticky     = sticky_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with short cycle parameters and hand-computed expectations.
module tb_reset_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig;
    logic       lock;
    logic       clr;
    logic [2:0] rst_o;
    logic       await_o;
    logic       ready_o;
    logic [2:0] state_o;
    logic       sticky_o;

    int checks = 0;
    int errors = 0;

    reset_seq_ctrl #(
        .NUM_STAGES   (3),
        .RESET_CYCLES (8),
        .LOCK_FILTER  (4),
        .STAGE_GAP    (2),
        .INIT_CYCLES  (16),
        .CNT_W        (8)
    ) dut (
        .i_slowest_clk          (clk),
        .i_rst_n                (rst_n),
        .i_reset_trigger        (trig),
        .i_pll_locked           (lock),
        .i_clear_sticky         (clr),
        .o_reset                (rst_o),
        .o_await_initialization (await_o),
        .o_ready                (ready_o),
        .o_state                (state_o),
        .o_lock_lost_sticky     (sticky_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after edge E0, with reset just released.
    task automatic apply_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        trig  = 1'b0;
        lock  = 1'b1;
        clr   = 1'b0;
        tick(2);
        checks++; if (rst_o !== 3'b111) begin errors++;
            $display("FAIL reset_o_reset got %b want 111", rst_o); end
        checks++; if (state_o !== 3'd0) begin errors++;
            $display("FAIL reset_state got %0d want 0", state_o); end
        checks++; if (await_o !== 1'b1) begin errors++;
            $display("FAIL reset_await got %b want 1", await_o); end
        checks++; if (ready_o !== 1'b0) begin errors++;
            $display("FAIL reset_ready got %b want 0", ready_o); end
        checks++; if (sticky_o !== 1'b0) begin errors++;
            $display("FAIL reset_sticky got %b want 0", sticky_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_power_on();
        tick(7);
        checks++; if (state_o !== 3'd0 || rst_o !== 3'b111) begin errors++;
            $display("FAIL po_hold_end got %0d/%b want 0/111", state_o, rst_o); end
        tick(1);
        checks++; if (state_o !== 3'd1 || rst_o !== 3'b111) begin errors++;
            $display("FAIL po_wait got %0d/%b want 1/111", state_o, rst_o); end
        tick(3);
        checks++; if (state_o !== 3'd1) begin errors++;
            $display("FAIL po_wait_end got %0d want 1", state_o); end
        tick(1);
        checks++; if (state_o !== 3'd2 || rst_o !== 3'b110) begin errors++;
            $display("FAIL po_rel0 got %0d/%b want 2/110", state_o, rst_o); end
        tick(1);
        checks++; if (rst_o !== 3'b110) begin errors++;
            $display("FAIL po_rel1 got %b want 110", rst_o); end
        tick(1);
        checks++; if (rst_o !== 3'b100) begin errors++;
            $display("FAIL po_rel2 got %b want 100", rst_o); end
        tick(2);
        checks++; if (state_o !== 3'd2 || rst_o !== 3'b000) begin errors++;
            $display("FAIL po_rel4 got %0d/%b want 2/000", state_o, rst_o); end
        tick(1);
        checks++; if (state_o !== 3'd3 || rst_o !== 3'b000) begin errors++;
            $display("FAIL po_init got %0d/%b want 3/000", state_o, rst_o); end
        tick(15);
        checks++; if (ready_o !== 1'b0 || await_o !== 1'b1) begin errors++;
            $display("FAIL po_init_end got rdy %b await %b want 0 1", ready_o, await_o); end
        tick(1);
        checks++; if (ready_o !== 1'b1 || await_o !== 1'b0 || state_o !== 3'd4) begin errors++;
            $display("FAIL po_ready got rdy %b await %b st %0d want 1 0 4",
                     ready_o, await_o, state_o); end
    endtask

    // Synced lock samples seen in WAIT_LOCK: 1,1,0,1,1,1,1.
    task automatic test_lock_filter();
        apply_reset();
        tick(8);
        checks++; if (state_o !== 3'd1) begin errors++;
            $display("FAIL lf_wait got %0d want 1", state_o); end
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(3);
        checks++; if (state_o !== 3'd1 || rst_o !== 3'b111) begin errors++;
            $display("FAIL lf_restart got %0d/%b want 1/111", state_o, rst_o); end
        tick(2);
        checks++; if (state_o !== 3'd1) begin errors++;
            $display("FAIL lf_three got %0d want 1", state_o); end
        tick(1);
        checks++; if (state_o !== 3'd2 || rst_o !== 3'b110) begin errors++;
            $display("FAIL lf_release got %0d/%b want 2/110", state_o, rst_o); end
    endtask

    // Continues from test_lock_filter (RELEASE entered at E15).
    task automatic test_lock_loss();
        tick(5);
        checks++; if (state_o !== 3'd3) begin errors++;
            $display("FAIL ll_init got %0d want 3", state_o); end
        tick(3);
        lock = 1'b0;
        tick(2);
        checks++; if (state_o !== 3'd3 || rst_o !== 3'b000) begin errors++;
            $display("FAIL ll_init5 got %0d/%b want 3/000", state_o, rst_o); end
        clr = 1'b1;
        tick(1);
        checks++; if (state_o !== 3'd0 || rst_o !== 3'b111) begin errors++;
            $display("FAIL ll_hold got %0d/%b want 0/111", state_o, rst_o); end
        checks++; if (sticky_o !== 1'b1) begin errors++;
            $display("FAIL ll_sticky_set_wins got %b want 1", sticky_o); end
        checks++; if (ready_o !== 1'b0 || await_o !== 1'b1) begin errors++;
            $display("FAIL ll_flags got rdy %b await %b want 0 1", ready_o, await_o); end
        clr  = 1'b0;
        lock = 1'b1;
        tick(4);
        checks++; if (sticky_o !== 1'b1) begin errors++;
            $display("FAIL ll_sticky_held got %b want 1", sticky_o); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        checks++; if (sticky_o !== 1'b0) begin errors++;
            $display("FAIL ll_sticky_clear got %b want 0", sticky_o); end
        tick(3);
        checks++; if (state_o !== 3'd1) begin errors++;
            $display("FAIL ll_rerun_wait got %0d want 1", state_o); end
        tick(4);
        checks++; if (state_o !== 3'd2 || rst_o !== 3'b110) begin errors++;
            $display("FAIL ll_rerun_rel got %0d/%b want 2/110", state_o, rst_o); end
        tick(21);
        checks++; if (state_o !== 3'd4 || ready_o !== 1'b1) begin errors++;
            $display("FAIL ll_rerun_ready got %0d/%b want 4/1", state_o, ready_o); end
    endtask

    // Continues from READY.
    task automatic test_trigger_ready();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(1);
        checks++; if (ready_o !== 1'b1) begin errors++;
            $display("FAIL tr_early got %b want 1", ready_o); end
        tick(1);
        checks++; if (ready_o !== 1'b0 || rst_o !== 3'b111 || state_o !== 3'd0) begin errors++;
            $display("FAIL tr_hold got rdy %b rst %b st %0d want 0 111 0",
                     ready_o, rst_o, state_o); end
        checks++; if (await_o !== 1'b1 || sticky_o !== 1'b0) begin errors++;
            $display("FAIL tr_flags got await %b sticky %b want 1 0", await_o, sticky_o); end
        tick(8);
        checks++; if (state_o !== 3'd1) begin errors++;
            $display("FAIL tr_wait got %0d want 1", state_o); end
        tick(4);
        checks++; if (state_o !== 3'd2 || rst_o !== 3'b110) begin errors++;
            $display("FAIL tr_rel got %0d/%b want 2/110", state_o, rst_o); end
        tick(5);
        checks++; if (state_o !== 3'd3 || rst_o !== 3'b000) begin errors++;
            $display("FAIL tr_init got %0d/%b want 3/000", state_o, rst_o); end
        tick(15);
        checks++; if (ready_o !== 1'b0) begin errors++;
            $display("FAIL tr_not_ready got %b want 0", ready_o); end
        tick(1);
        checks++; if (ready_o !== 1'b1 || state_o !== 3'd4) begin errors++;
            $display("FAIL tr_ready got %b/%0d want 1/4", ready_o, state_o); end
    endtask

    // Edge is sampled at the end of HOLD cycle 6, i.e. at E7.
    task automatic test_trigger_hold();
        apply_reset();
        tick(4);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(2);
        checks++; if (state_o !== 3'd0) begin errors++;
            $display("FAIL th_edge got %0d want 0", state_o); end
        tick(1);
        checks++; if (state_o !== 3'd0 || rst_o !== 3'b111) begin errors++;
            $display("FAIL th_extended got %0d/%b want 0/111", state_o, rst_o); end
        tick(6);
        checks++; if (state_o !== 3'd0 || rst_o !== 3'b111) begin errors++;
            $display("FAIL th_last got %0d/%b want 0/111", state_o, rst_o); end
        tick(1);
        checks++; if (state_o !== 3'd1) begin errors++;
            $display("FAIL th_wait got %0d want 1", state_o); end
    endtask

    // Continues from test_trigger_hold (WAIT_LOCK entered at E15).
    task automatic test_async_reset();
        tick(6);
        checks++; if (rst_o !== 3'b100 || state_o !== 3'd2) begin errors++;
            $display("FAIL ar_pre got %b/%0d want 100/2", rst_o, state_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rst_o !== 3'b111 || state_o !== 3'd0) begin errors++;
            $display("FAIL ar_outputs got %b/%0d want 111/0", rst_o, state_o); end
        checks++; if (await_o !== 1'b1 || ready_o !== 1'b0 || sticky_o !== 1'b0) begin errors++;
            $display("FAIL ar_flags got %b %b %b want 1 0 0", await_o, ready_o, sticky_o); end
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_lock_filter();
        test_lock_loss();
        test_trigger_ready();
        test_trigger_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
